// File: rtl/sweep_capture.sv
// Exhaustive input sweep: drives binary or Gray patterns into a DUT, samples its
// response after a settle delay, streams (pattern, response) records and folds them into a CRC-16 signature.
module sweep_capture #(
    parameter int IN_W   = 6,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IN_W-1:0]  rec_pat,
    output logic [OUT_W-1:0] rec_resp,
    output logic [15:0]      sig,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SAMPLE = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [IN_W-1:0] IDX_LAST    = {IN_W{1'b1}};
    localparam logic [IN_W-1:0] IDX_ONE     = IN_W'(1'b1);
    localparam logic [15:0]     SIG_SEED    = 16'hFFFF;

    // Sequence generator: plain binary count or its reflected Gray code.
    function automatic logic [IN_W-1:0] seq_pat(input logic [IN_W-1:0] idx, input logic gray);
        if (gray) begin
            seq_pat = idx ^ (idx >> 1'b1);
        end else begin
            seq_pat = idx;
        end
    endfunction

    // One CRC-16/CCITT shift with the sampled {pattern, response} folded in.
    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [IN_W-1:0] p,
                                             input logic [OUT_W-1:0] r);
        sig_step = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'({p, r});
    endfunction

    state_e            state_q, state_d;
    logic [IN_W-1:0]   idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [IN_W-1:0]   stim_q, stim_d;
    logic              rec_valid_q, rec_valid_d;
    logic [IN_W-1:0]   rec_pat_q, rec_pat_d;
    logic [OUT_W-1:0]  rec_resp_q, rec_resp_d;
    logic [15:0]       sig_q, sig_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              in_sweep_s;

    // Next-state and datapath decode; abort in a busy state overrides everything.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        stim_d      = stim_q;
        rec_valid_d = rec_valid_q;
        rec_pat_d   = rec_pat_q;
        rec_resp_d  = rec_resp_q;
        sig_d       = sig_q;
        aborted_d   = aborted_q;
        in_sweep_s  = (state_q == APPLY) || (state_q == SAMPLE) || (state_q == EMIT);

        if (in_sweep_s && abort) begin
            state_d     = DONE;
            aborted_d   = 1'b1;
            rec_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = APPLY;
                        idx_d     = '0;
                        cnt_d     = 8'd0;
                        mode_d    = mode;
                        stim_d    = seq_pat('0, mode);
                        sig_d     = SIG_SEED;
                        aborted_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                APPLY: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SAMPLE: begin
                    rec_resp_d  = resp;
                    rec_pat_d   = stim_q;
                    sig_d       = sig_step(sig_q, stim_q, resp);
                    rec_valid_d = 1'b1;
                    state_d     = EMIT;
                end
                EMIT: begin
                    if (rec_ready) begin
                        rec_valid_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            stim_d  = seq_pat(idx_q + IDX_ONE, mode_q);
                            cnt_d   = 8'd0;
                            state_d = APPLY;
                        end
                    end else begin
                        state_d = EMIT;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    rec_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == APPLY) || (state_d == SAMPLE) || (state_d == EMIT);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= 8'd0;
            mode_q      <= 1'b0;
            stim_q      <= '0;
            rec_valid_q <= 1'b0;
            rec_pat_q   <= '0;
            rec_resp_q  <= '0;
            sig_q       <= SIG_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            stim_q      <= stim_d;
            rec_valid_q <= rec_valid_d;
            rec_pat_q   <= rec_pat_d;
            rec_resp_q  <= rec_resp_d;
            sig_q       <= sig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign stim      = stim_q;
    assign rec_valid = rec_valid_q;
    assign rec_pat   = rec_pat_q;
    assign rec_resp  = rec_resp_q;
    assign sig       = sig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_sweep_capture.sv
// Scoreboard bench for sweep_capture: expected records are queued at start and
// matched against every rec_valid/rec_ready handshake.
module tb_sweep_capture;

    localparam int IN_W   = 6;
    localparam int OUT_W  = 1;
    localparam int SETTLE = 1;
    localparam int N      = 1 << IN_W;

    typedef struct {
        logic [IN_W-1:0]  pat;
        logic [OUT_W-1:0] resp;
        logic [15:0]      sig;
    } rec_t;

    logic             CK = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic             abort;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] resp;
    logic             rec_valid;
    logic             rec_ready;
    logic [IN_W-1:0]  rec_pat;
    logic [OUT_W-1:0] rec_resp;
    logic [15:0]      sig;
    logic             busy;
    logic             done;
    logic             aborted;

    int   total = 0;
    int   bad   = 0;
    int   rec_cnt = 0;
    bit   rand_ready = 1'b0;
    rec_t exp_q[$];

    logic             prev_stall = 1'b0;
    logic [IN_W-1:0]  prev_pat;
    logic [OUT_W-1:0] prev_resp;
    logic [IN_W-1:0]  prev_stim;
    logic [15:0]      prev_sig;

    sweep_capture #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .CK(CK), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .stim(stim), .resp(resp), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_pat(rec_pat), .rec_resp(rec_resp), .sig(sig),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 CK = ~CK;

    // The device under sweep is a parity tree.
    assign resp = ^stim;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] ref_pat(input int i, input bit m);
        logic [IN_W-1:0] v;
        v = IN_W'(i);
        return m ? (v ^ (v >> 1)) : v;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [IN_W-1:0] p,
                                             input logic [OUT_W-1:0] r);
        logic [15:0] fb;
        logic [15:0] din;
        fb  = s[15] ? 16'h1021 : 16'h0000;
        din = 16'({p, r});
        return (s << 1) ^ fb ^ din;
    endfunction

    function automatic logic [15:0] ref_sig(input int n, input bit m);
        logic [15:0] s;
        logic [IN_W-1:0] p;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            p = ref_pat(i, m);
            s = ref_step(s, p, ^p);
        end
        return s;
    endfunction

    task automatic push_sweep(input bit m);
        rec_t r;
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            r.pat  = ref_pat(i, m);
            r.resp = OUT_W'(^r.pat);
            s      = ref_step(s, r.pat, r.resp);
            r.sig  = s;
            exp_q.push_back(r);
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
        if (rand_ready) rec_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start(input bit m, input bit ab);
        start = 1'b1;
        mode  = m;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 4000) begin
            tick();
            cyc++;
        end
        check_val("done_reached", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_stim"}, 32'(stim), 32'd0);
        check_val({tag, "_valid"}, 32'(rec_valid), 32'd0);
        check_val({tag, "_pat"}, 32'(rec_pat), 32'd0);
        check_val({tag, "_resp"}, 32'(rec_resp), 32'd0);
        check_val({tag, "_sig"}, 32'(sig), 32'h0000FFFF);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_aborted"}, 32'(aborted), 32'd0);
    endtask

    // Record monitor: stability under backpressure and scoreboard match on each handshake.
    always @(negedge CK) begin
        if (reset) begin
            if (prev_stall && rec_valid) begin
                check_val("stall_pat", 32'(rec_pat), 32'(prev_pat));
                check_val("stall_resp", 32'(rec_resp), 32'(prev_resp));
                check_val("stall_stim", 32'(stim), 32'(prev_stim));
                check_val("stall_sig", 32'(sig), 32'(prev_sig));
            end
            if (rec_valid && rec_ready) begin
                check_val("rec_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    rec_t e;
                    e = exp_q.pop_front();
                    check_val("rec_pat", 32'(rec_pat), 32'(e.pat));
                    check_val("rec_resp", 32'(rec_resp), 32'(e.resp));
                    check_val("rec_sig", 32'(sig), 32'(e.sig));
                end
                rec_cnt <= rec_cnt + 1;
            end
            prev_stall <= rec_valid && !rec_ready;
        end else begin
            prev_stall <= 1'b0;
        end
        prev_pat  <= rec_pat;
        prev_resp <= rec_resp;
        prev_stim <= stim;
        prev_sig  <= sig;
    end

    initial begin
        int cyc;
        int guard;
        reset = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        abort = 1'b0;
        rec_ready = 1'b1;
        #3 reset = 1'b0;
        #4 check_reset_outputs("por");
        repeat (2) tick();
        @(negedge CK) reset = 1'b1;
        tick();
        check_reset_outputs("idle");

        // Binary sweep with rec_ready tied high.
        rec_cnt = 0;
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        check_val("bin_busy", 32'(busy), 32'd1);
        run_to_done(cyc);
        check_val("bin_latency", 32'(cyc), 32'(N * (SETTLE + 2)));
        check_val("bin_count", 32'(rec_cnt), 32'(N));
        check_val("bin_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("bin_sig", 32'(sig), 32'(ref_sig(N, 1'b0)));
        check_val("bin_busy_end", 32'(busy), 32'd0);
        repeat (3) tick();
        check_val("bin_done_held", 32'(done), 32'd1);
        check_val("bin_no_wrap", 32'(rec_cnt), 32'(N));

        // Gray sweep.
        rec_cnt = 0;
        push_sweep(1'b1);
        pulse_start(1'b1, 1'b0);
        check_val("gray_done_clr", 32'(done), 32'd0);
        run_to_done(cyc);
        check_val("gray_count", 32'(rec_cnt), 32'(N));
        check_val("gray_sig", 32'(sig), 32'(ref_sig(N, 1'b1)));

        // Random backpressure.
        rec_cnt = 0;
        rand_ready = 1'b1;
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        run_to_done(cyc);
        rand_ready = 1'b0;
        rec_ready = 1'b1;
        check_val("rnd_count", 32'(rec_cnt), 32'(N));
        check_val("rnd_q_empty", 32'(exp_q.size()), 32'd0);

        // Abort while record 10 is pending.
        rec_cnt = 0;
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        guard = 0;
        while (!(rec_valid && rec_pat == IN_W'(10)) && guard < 500) begin
            tick();
            guard++;
        end
        check_val("abt_reach10", 32'(rec_valid && rec_pat == IN_W'(10)), 32'd1);
        rec_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abt_valid", 32'(rec_valid), 32'd0);
        check_val("abt_done", 32'(done), 32'd1);
        check_val("abt_flag", 32'(aborted), 32'd1);
        check_val("abt_busy", 32'(busy), 32'd0);
        check_val("abt_sig", 32'(sig), 32'(ref_sig(11, 1'b0)));
        check_val("abt_count", 32'(rec_cnt), 32'd10);
        exp_q.delete();
        rec_ready = 1'b1;
        repeat (3) tick();
        check_val("abt_sig_frozen", 32'(sig), 32'(ref_sig(11, 1'b0)));

        // Reset during APPLY of idx 5, then a fresh sweep.
        rec_cnt = 0;
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        guard = 0;
        while (stim != IN_W'(5) && guard < 500) begin
            tick();
            guard++;
        end
        check_val("rst_reach5", 32'(stim), 32'd5);
        reset = 1'b0;
        #1 check_reset_outputs("rst_mid");
        tick();
        check_reset_outputs("rst_hold");
        @(negedge CK) reset = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        check_val("rst_no_resume", 32'(busy), 32'd0);
        check_val("rst_no_rec", 32'(rec_valid), 32'd0);
        rec_cnt = 0;
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        check_val("rst_seed", 32'(sig), 32'h0000FFFF);
        check_val("rst_stim0", 32'(stim), 32'd0);
        run_to_done(cyc);
        check_val("rst_count", 32'(rec_cnt), 32'(N));

        // Start while busy is ignored.
        rec_cnt = 0;
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        repeat (20) tick();
        pulse_start(1'b1, 1'b0);
        run_to_done(cyc);
        check_val("bsy_start_count", 32'(rec_cnt), 32'(N));
        check_val("bsy_start_abt", 32'(aborted), 32'd0);

        // Start+abort while busy: abort wins.
        push_sweep(1'b0);
        pulse_start(1'b0, 1'b0);
        repeat (7) tick();
        rec_ready = 1'b0;
        pulse_start(1'b0, 1'b1);
        check_val("sa_busy_done", 32'(done), 32'd1);
        check_val("sa_busy_abt", 32'(aborted), 32'd1);
        check_val("sa_busy_busy", 32'(busy), 32'd0);
        exp_q.delete();
        rec_ready = 1'b1;

        // Start+abort in DONE: start wins.
        rec_cnt = 0;
        push_sweep(1'b1);
        pulse_start(1'b1, 1'b1);
        check_val("sa_done_busy", 32'(busy), 32'd1);
        check_val("sa_done_done", 32'(done), 32'd0);
        check_val("sa_done_abt", 32'(aborted), 32'd0);
        run_to_done(cyc);
        check_val("sa_done_count", 32'(rec_cnt), 32'(N));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
